exc_irq_ctrl: RTL and testbench

- Sequential interrupt/exception controller for the 5-stage pipeline; replaces the single IRQ/ker gating in the decoder.
- Supports N_IRQ masked interrupt lines, undefined-instruction and privilege traps, and tracks kernel mode.
- Saves EPC/cause and drives the PC-redirect and IF/ID-flush requests.
- Makes every trap/return decision from the instruction in ID.

---
 rtl/exc_pkg.sv | 24 ++
 rtl/irq_prio_enc.sv | 20 ++
 rtl/exc_irq_ctrl.sv | 162 ++++++++++++++++
 tb/tb_exc_irq_ctrl.sv | 510 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exc_pkg.sv
// Shared types and constants for the interrupt/exception controller.
// Holds the privilege state encoding, cause-type codes and default vector addresses.
package exc_pkg;

   typedef enum logic [1:0] {
      USER   = 2'd0,
      KERNEL = 2'd1,
      GRACE  = 2'd2
   } state_t;

   localparam logic [1:0] CAUSE_NONE  = 2'b00;
   localparam logic [1:0] CAUSE_IRQ   = 2'b01;
   localparam logic [1:0] CAUSE_UNDEF = 2'b10;
   localparam logic [1:0] CAUSE_PRIV  = 2'b11;

   localparam logic [31:0] IRQ_VEC_DFLT = 32'h8000_0004;
   localparam logic [31:0] EXC_VEC_DFLT = 32'h8000_0008;

   // A single line still needs a 1-bit index bus internally.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder over the pending interrupt lines.
// Purely combinational, zero latency; no flow control.
module irq_prio_enc #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  i_req,
   output logic          o_any,
   output logic [IW-1:0] o_idx
);

   always_comb begin
      o_any = |i_req;
      o_idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (i_req[i]) o_idx = IW'(i);
      end
   end

endmodule

// File: rtl/exc_irq_ctrl.sv
// Trap/return controller deciding from the ID instruction; trap/ret are combinational, EPC/cause/state update next edge.
// Decisions only when ID is valid and not stalled; EXC_IRQ_SYNC_EN adds a 2-flop irq synchronizer.
module exc_irq_ctrl
   import exc_pkg::*;
#(
   parameter int               N_IRQ    = 4,
   parameter int               PC_W     = 32,
   parameter logic [PC_W-1:0]  IRQ_VEC  = PC_W'(IRQ_VEC_DFLT),
   parameter logic [PC_W-1:0]  EXC_VEC  = PC_W'(EXC_VEC_DFLT),
   parameter logic [N_IRQ-1:0] MASK_RST = '0
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [N_IRQ-1:0]          irq,
   input  logic                      id_valid,
   input  logic                      id_stall,
   input  logic [PC_W-1:0]           id_pc,
   input  logic                      id_undef,
   input  logic                      id_eret,
   input  logic                      mask_wr,
   input  logic [N_IRQ-1:0]          mask_din,
   output logic                      ker,
   output logic                      trap,
   output logic                      ret,
   output logic [PC_W-1:0]           vec_pc,
   output logic [PC_W-1:0]           epc,
   output logic [$clog2(N_IRQ)+1:0]  cause,
   output logic [N_IRQ-1:0]          irq_mask,
   output logic                      dbl_fault
);

   localparam int CW = $clog2(N_IRQ) + 2;
   localparam int IW = idx_w(N_IRQ);

   logic [N_IRQ-1:0] w_irq_q;
   logic [N_IRQ-1:0] w_pend;
   logic             w_any;
   logic [IW-1:0]    w_idx;
   logic             w_go;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [PC_W-1:0]  r_epc;
   logic [PC_W-1:0]  w_epc_nxt;
   logic [CW-1:0]    r_cause;
   logic [CW-1:0]    w_cause_nxt;
   logic [1:0]       w_type;
   logic [IW-1:0]    w_cidx;
   logic [N_IRQ-1:0] r_mask;
   logic             r_dbl;
   logic             w_dbl_set;
   logic             w_trap;
   logic             w_ret;
   logic [PC_W-1:0]  w_vec;

`ifdef EXC_IRQ_SYNC_EN
   logic [N_IRQ-1:0] r_sync1;
   logic [N_IRQ-1:0] r_sync2;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= irq;
         r_sync2 <= r_sync1;
      end
   end

   assign w_irq_q = r_sync2;
`else
   assign w_irq_q = irq;
`endif

   assign w_go   = id_valid & ~id_stall;
   assign w_pend = w_irq_q & r_mask;

   irq_prio_enc #(.N(N_IRQ), .IW(IW)) u_prio (
      .i_req (w_pend),
      .o_any (w_any),
      .o_idx (w_idx)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_trap      = 1'b0;
      w_ret       = 1'b0;
      w_vec       = '0;
      w_epc_nxt   = r_epc;
      w_type      = CAUSE_NONE;
      w_cidx      = '0;
      w_dbl_set   = 1'b0;
      case (r_state)
         USER, GRACE: begin
            if (w_go) begin
               if (id_undef) begin
                  w_trap    = 1'b1;
                  w_type    = CAUSE_UNDEF;
                  w_epc_nxt = id_pc + PC_W'(4);
                  w_vec     = EXC_VEC;
               end else if (id_eret) begin
                  w_trap    = 1'b1;
                  w_type    = CAUSE_PRIV;
                  w_epc_nxt = id_pc + PC_W'(4);
                  w_vec     = EXC_VEC;
               end else if (r_state == USER && w_any) begin
                  // The interrupted instruction is re-executed after return.
                  w_trap    = 1'b1;
                  w_type    = CAUSE_IRQ;
                  w_cidx    = w_idx;
                  w_epc_nxt = id_pc;
                  w_vec     = IRQ_VEC;
               end else begin
                  w_state_nxt = USER;
               end
               if (w_trap) w_state_nxt = KERNEL;
            end
         end
         KERNEL: begin
            if (w_go) begin
               if (id_undef) begin
                  w_dbl_set = 1'b1;
               end else if (id_eret) begin
                  w_ret       = 1'b1;
                  w_state_nxt = GRACE;
               end
            end
         end
         default: w_state_nxt = USER;
      endcase
   end

   assign w_cause_nxt = (CW'(w_type) << (CW - 2)) | CW'(w_cidx);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= USER;
         r_epc   <= '0;
         r_cause <= '0;
         r_mask  <= MASK_RST;
         r_dbl   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_trap) begin
            r_epc   <= w_epc_nxt;
            r_cause <= w_cause_nxt;
         end
         if (r_state == KERNEL && mask_wr) r_mask <= mask_din;
         if (w_dbl_set) r_dbl <= 1'b1;
      end
   end

   assign ker       = (r_state == KERNEL);
   assign trap      = w_trap;
   assign ret       = w_ret;
   assign vec_pc    = w_vec;
   assign epc       = r_epc;
   assign cause     = r_cause;
   assign irq_mask  = r_mask;
   assign dbl_fault = r_dbl;

endmodule

// File: tb/tb_exc_irq_ctrl.sv
// Scoreboard bench for exc_irq_ctrl: expectations are queued as stimulus is driven and drained at the sample point.
module tb_exc_irq_ctrl;

   localparam int N  = 4;
   localparam int PW = 32;
   localparam int CW = 4;

   localparam logic [31:0] IVEC = 32'h8000_0004;
   localparam logic [31:0] EVEC = 32'h8000_0008;

   localparam int S_TRAP  = 0;
   localparam int S_RET   = 1;
   localparam int S_VEC   = 2;
   localparam int S_KER   = 3;
   localparam int S_EPC   = 4;
   localparam int S_CAUSE = 5;
   localparam int S_MASK  = 6;
   localparam int S_DBL   = 7;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [N-1:0]  irq = '0;
   logic          id_valid = 1'b0;
   logic          id_stall = 1'b0;
   logic [PW-1:0] id_pc = '0;
   logic          id_undef = 1'b0;
   logic          id_eret = 1'b0;
   logic          mask_wr = 1'b0;
   logic [N-1:0]  mask_din = '0;
   logic          ker, trap, ret, dbl_fault;
   logic [PW-1:0] vec_pc, epc;
   logic [CW-1:0] cause;
   logic [N-1:0]  irq_mask;

   typedef struct {
      string       name;
      int          sel;
      logic [31:0] val;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   exc_irq_ctrl #(
      .N_IRQ(N), .PC_W(PW), .IRQ_VEC(IVEC), .EXC_VEC(EVEC), .MASK_RST(4'b0000)
   ) dut (
      .clk(clk), .reset(reset), .irq(irq), .id_valid(id_valid), .id_stall(id_stall),
      .id_pc(id_pc), .id_undef(id_undef), .id_eret(id_eret), .mask_wr(mask_wr),
      .mask_din(mask_din), .ker(ker), .trap(trap), .ret(ret), .vec_pc(vec_pc),
      .epc(epc), .cause(cause), .irq_mask(irq_mask), .dbl_fault(dbl_fault)
   );

   function automatic logic [31:0] obs(input int s);
      case (s)
         S_TRAP:  return 32'(trap);
         S_RET:   return 32'(ret);
         S_VEC:   return vec_pc;
         S_KER:   return 32'(ker);
         S_EPC:   return epc;
         S_CAUSE: return 32'(cause);
         S_MASK:  return 32'(irq_mask);
         default: return 32'(dbl_fault);
      endcase
   endfunction

   task automatic push(input string n, input int s, input logic [31:0] v);
      exp_t e;
      e.name = n;
      e.sel  = s;
      e.val  = v;
      sb.push_back(e);
   endtask

   task automatic drive(input logic v, input logic st, input logic [31:0] pc,
                        input logic u, input logic er);
      id_valid = v;
      id_stall = st;
      id_pc    = pc;
      id_undef = u;
      id_eret  = er;
   endtask

   task automatic next_cyc;
      @(posedge clk);
      #1;
   endtask

   // Kernel -> GRACE -> USER without checks (covered elsewhere).
   task automatic leave_kernel;
      drive(1, 0, 32'h0000_0F00, 0, 1);
      next_cyc();
      drive(1, 0, 32'h0000_0F04, 0, 0);
      next_cyc();
      drive(0, 0, 0, 0, 0);
   endtask

   task automatic test_reset;
      exp_t e;
      reset = 1'b0;
      drive(0, 0, 0, 0, 0);
      push("rst_trap", S_TRAP, 0);
      push("rst_ret", S_RET, 0);
      push("rst_vec", S_VEC, 0);
      push("rst_ker", S_KER, 0);
      push("rst_epc", S_EPC, 0);
      push("rst_cause", S_CAUSE, 0);
      push("rst_mask", S_MASK, 0);
      push("rst_dbl", S_DBL, 0);
      @(negedge clk);
      while (sb.size() > 0) begin
         e = sb.pop_front(); n_cmp++;
         if (obs(e.sel) !== e.val) begin
            n_bad++; $display("FAIL %s: got %h want %h", e.name, obs(e.sel), e.val);
         end
      end
      @(posedge clk);
      #1 reset = 1'b1;
      next_cyc();
   endtask

   task automatic test_irq_entry;
      exp_t e;
      irq = '0;
      drive(1, 0, 32'h0, 1, 0);
      push("boot_trap", S_TRAP, 1);
      push("boot_vec", S_VEC, EVEC);
      @(negedge clk);
      while (sb.size() > 0) begin
         e = sb.pop_front(); n_cmp++;
         if (obs(e.sel) !== e.val) begin
            n_bad++; $display("FAIL %s: got %h want %h", e.name, obs(e.sel), e.val);
         end
      end
      next_cyc();
      drive(0, 0, 0, 0, 0);
      mask_wr = 1'b1; mask_din = 4'b1111;
      push("boot_ker", S_KER, 1);
      push("boot_epc", S_EPC, 32'h4);
      push("boot_cause", S_CAUSE, 32'h8);
      @(negedge clk);
      while (sb.size() > 0) begin
         e = sb.pop_front(); n_cmp++;
         if (obs(e.sel) !== e.val) begin
            n_bad++; $display("FAIL %s: got %h want %h", e.name, obs(e.sel), e.val);
         end
      end
      next_cyc();
      mask_wr = 1'b0;
      drive(1, 0, 32'h10, 0, 1);
      push("kmask", S_MASK, 32'hF);
      push("eret_ret", S_RET, 1);
      push("eret_trap", S_TRAP, 0);
      @(negedge clk);
      while (sb.size() > 0) begin
         e = sb.pop_front(); n_cmp++;
         if (obs(e.sel) !== e.val) begin
            n_bad++; $display("FAIL %s: got %h want %h", e.name, obs(e.sel), e.val);
         end
      end
      next_cyc();
      drive(1, 0, 32'h20, 0, 0);
      push("grace_ker", S_KER, 0);
      next_cyc();
      irq = 4'b0110;
      drive(1, 0, 32'h0040_0010, 0, 0);
      push("irq_trap", S_TRAP, 1);
      push("irq_vec", S_VEC, IVEC);
      push("irq_ret", S_RET, 0);
      @(negedge clk);
      while (sb.size() > 0) begin
         e = sb.pop_front(); n_cmp++;
         if (obs(e.sel) !== e.val) begin
            n_bad++; $display("FAIL %s: got %h want %h", e.name, obs(e.sel), e.val);
         end
      end
      next_cyc();
      drive(0, 0, 0, 0, 0);
      push("irq_ker", S_KER, 1);
      push("irq_epc", S_EPC, 32'h0040_0010);
      push("irq_cause", S_CAUSE, 32'h5);
      push("irq_trap_off", S_TRAP, 0);
      push("irq_vec_zero", S_VEC, 0);
      @(negedge clk);
      while (sb.size() > 0) begin
         e = sb.pop_front(); n_cmp++;
         if (obs(e.sel) !== e.val) begin
            n_bad++; $display("FAIL %s: got %h want %h", e.name, obs(e.sel), e.val);
         end
      end
      irq = '0;
      next_cyc();
   endtask

   task automatic test_undef_prio;
      exp_t e;
      leave_kernel();
      irq = 4'b0001;
      drive(1, 0, 32'h100, 1, 0);
      push("undef_trap", S_TRAP, 1);
      push("undef_vec", S_VEC, EVEC);
      @(negedge clk);
      while (sb.size() > 0) begin
         e = sb.pop_front(); n_cmp++;
         if (obs(e.sel) !== e.val) begin
            n_bad++; $display("FAIL %s: got %h want %h", e.name, obs(e.sel), e.val);
         end
      end
      next_cyc();
      drive(0, 0, 0, 0, 0);
      push("undef_epc", S_EPC, 32'h104);
      push("undef_cause", S_CAUSE, 32'h8);
      push("undef_ker", S_KER, 1);
      @(negedge clk);
      while (sb.size() > 0) begin
         e = sb.pop_front(); n_cmp++;
         if (obs(e.sel) !== e.val) begin
            n_bad++; $display("FAIL %s: got %h want %h", e.name, obs(e.sel), e.val);
         end
      end
      next_cyc();
   endtask

   task automatic test_return_grace;
      exp_t e;
      drive(1, 0, 32'h200, 0, 1);
      push("rg_ret", S_RET, 1);
      push("rg_trap", S_TRAP, 0);
      push("rg_vec", S_VEC, 0);
      @(negedge clk);
      while (sb.size() > 0) begin
         e = sb.pop_front(); n_cmp++;
         if (obs(e.sel) !== e.val) begin
            n_bad++; $display("FAIL %s: got %h want %h", e.name, obs(e.sel), e.val);
         end
      end
      next_cyc();
      for (int i = 0; i < 2; i++) begin
         drive(0, 0, 0, 0, 0);
         push("rg_idle_ker", S_KER, 0);
         push("rg_idle_trap", S_TRAP, 0);
         @(negedge clk);
         while (sb.size() > 0) begin
            e = sb.pop_front(); n_cmp++;
            if (obs(e.sel) !== e.val) begin
               n_bad++; $display("FAIL %s: got %h want %h", e.name, obs(e.sel), e.val);
            end
         end
         next_cyc();
      end
      drive(1, 0, 32'h300, 0, 0);
      push("rg_grace_block", S_TRAP, 0);
      @(negedge clk);
      while (sb.size() > 0) begin
         e = sb.pop_front(); n_cmp++;
         if (obs(e.sel) !== e.val) begin
            n_bad++; $display("FAIL %s: got %h want %h", e.name, obs(e.sel), e.val);
         end
      end
      next_cyc();
      drive(1, 0, 32'h304, 0, 0);
      push("rg_after_trap", S_TRAP, 1);
      push("rg_after_vec", S_VEC, IVEC);
      @(negedge clk);
      while (sb.size() > 0) begin
         e = sb.pop_front(); n_cmp++;
         if (obs(e.sel) !== e.val) begin
            n_bad++; $display("FAIL %s: got %h want %h", e.name, obs(e.sel), e.val);
         end
      end
      next_cyc();
      drive(0, 0, 0, 0, 0);
      push("rg_epc", S_EPC, 32'h304);
      push("rg_cause", S_CAUSE, 32'h4);
      @(negedge clk);
      while (sb.size() > 0) begin
         e = sb.pop_front(); n_cmp++;
         if (obs(e.sel) !== e.val) begin
            n_bad++; $display("FAIL %s: got %h want %h", e.name, obs(e.sel), e.val);
         end
      end
      irq = '0;
      next_cyc();
   endtask

   task automatic test_stall_defer;
      exp_t e;
      leave_kernel();
      irq = 4'b0100;
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 32'h500, 0, 0);
         push("stall_trap", S_TRAP, 0);
         @(negedge clk);
         while (sb.size() > 0) begin
            e = sb.pop_front(); n_cmp++;
            if (obs(e.sel) !== e.val) begin
               n_bad++; $display("FAIL %s: got %h want %h", e.name, obs(e.sel), e.val);
            end
         end
         next_cyc();
      end
      drive(1, 0, 32'h500, 0, 0);
      push("unstall_trap", S_TRAP, 1);
      @(negedge clk);
      while (sb.size() > 0) begin
         e = sb.pop_front(); n_cmp++;
         if (obs(e.sel) !== e.val) begin
            n_bad++; $display("FAIL %s: got %h want %h", e.name, obs(e.sel), e.val);
         end
      end
      next_cyc();
      drive(0, 0, 0, 0, 0);
      irq = '0;
      push("unstall_epc", S_EPC, 32'h500);
      push("unstall_cause", S_CAUSE, 32'h6);
      @(negedge clk);
      while (sb.size() > 0) begin
         e = sb.pop_front(); n_cmp++;
         if (obs(e.sel) !== e.val) begin
            n_bad++; $display("FAIL %s: got %h want %h", e.name, obs(e.sel), e.val);
         end
      end
      next_cyc();
      leave_kernel();
      irq = 4'b0001;
      next_cyc();
      irq = '0;
      drive(1, 0, 32'h540, 0, 0);
      push("drop_trap", S_TRAP, 0);
      @(negedge clk);
      while (sb.size() > 0) begin
         e = sb.pop_front(); n_cmp++;
         if (obs(e.sel) !== e.val) begin
            n_bad++; $display("FAIL %s: got %h want %h", e.name, obs(e.sel), e.val);
         end
      end
      next_cyc();
      drive(0, 0, 0, 0, 0);
      push("drop_ker", S_KER, 0);
      @(negedge clk);
      while (sb.size() > 0) begin
         e = sb.pop_front(); n_cmp++;
         if (obs(e.sel) !== e.val) begin
            n_bad++; $display("FAIL %s: got %h want %h", e.name, obs(e.sel), e.val);
         end
      end
      next_cyc();
   endtask

   task automatic test_mask;
      exp_t e;
      mask_wr = 1'b1; mask_din = 4'b0000;
      drive(1, 0, 32'h5F0, 0, 0);
      next_cyc();
      mask_wr = 1'b0;
      drive(0, 0, 0, 0, 0);
      push("user_mask_wr", S_MASK, 32'hF);
      @(negedge clk);
      while (sb.size() > 0) begin
         e = sb.pop_front(); n_cmp++;
         if (obs(e.sel) !== e.val) begin
            n_bad++; $display("FAIL %s: got %h want %h", e.name, obs(e.sel), e.val);
         end
      end
      next_cyc();
      drive(1, 0, 32'h600, 1, 0);
      next_cyc();
      drive(0, 0, 0, 0, 0);
      mask_wr = 1'b1; mask_din = 4'b1110;
      next_cyc();
      mask_wr = 1'b0;
      push("kern_mask_wr", S_MASK, 32'hE);
      @(negedge clk);
      while (sb.size() > 0) begin
         e = sb.pop_front(); n_cmp++;
         if (obs(e.sel) !== e.val) begin
            n_bad++; $display("FAIL %s: got %h want %h", e.name, obs(e.sel), e.val);
         end
      end
      next_cyc();
      leave_kernel();
      irq = 4'b0001;
      drive(1, 0, 32'h6F0, 0, 0);
      push("masked_line", S_TRAP, 0);
      @(negedge clk);
      while (sb.size() > 0) begin
         e = sb.pop_front(); n_cmp++;
         if (obs(e.sel) !== e.val) begin
            n_bad++; $display("FAIL %s: got %h want %h", e.name, obs(e.sel), e.val);
         end
      end
      next_cyc();
      irq = 4'b0011;
      drive(1, 0, 32'h700, 0, 0);
      push("unmasked_trap", S_TRAP, 1);
      @(negedge clk);
      while (sb.size() > 0) begin
         e = sb.pop_front(); n_cmp++;
         if (obs(e.sel) !== e.val) begin
            n_bad++; $display("FAIL %s: got %h want %h", e.name, obs(e.sel), e.val);
         end
      end
      next_cyc();
      drive(0, 0, 0, 0, 0);
      irq = '0;
      push("masked_cause", S_CAUSE, 32'h5);
      push("masked_epc", S_EPC, 32'h700);
      @(negedge clk);
      while (sb.size() > 0) begin
         e = sb.pop_front(); n_cmp++;
         if (obs(e.sel) !== e.val) begin
            n_bad++; $display("FAIL %s: got %h want %h", e.name, obs(e.sel), e.val);
         end
      end
      next_cyc();
   endtask

   task automatic test_dbl_fault;
      exp_t e;
      drive(1, 0, 32'h800, 1, 0);
      push("kundef_trap", S_TRAP, 0);
      push("kundef_ret", S_RET, 0);
      @(negedge clk);
      while (sb.size() > 0) begin
         e = sb.pop_front(); n_cmp++;
         if (obs(e.sel) !== e.val) begin
            n_bad++; $display("FAIL %s: got %h want %h", e.name, obs(e.sel), e.val);
         end
      end
      next_cyc();
      drive(0, 0, 0, 0, 0);
      push("dbl_set", S_DBL, 1);
      push("dbl_ker", S_KER, 1);
      push("dbl_epc_kept", S_EPC, 32'h700);
      @(negedge clk);
      while (sb.size() > 0) begin
         e = sb.pop_front(); n_cmp++;
         if (obs(e.sel) !== e.val) begin
            n_bad++; $display("FAIL %s: got %h want %h", e.name, obs(e.sel), e.val);
         end
      end
      next_cyc();
      leave_kernel();
      push("dbl_sticky", S_DBL, 1);
      push("dbl_user", S_KER, 0);
      @(negedge clk);
      while (sb.size() > 0) begin
         e = sb.pop_front(); n_cmp++;
         if (obs(e.sel) !== e.val) begin
            n_bad++; $display("FAIL %s: got %h want %h", e.name, obs(e.sel), e.val);
         end
      end
      next_cyc();
      drive(1, 0, 32'h900, 1, 0);
      next_cyc();
      drive(0, 0, 0, 0, 0);
   endtask

   task automatic test_reset_mid;
      exp_t e;
      push("pre_rst_ker", S_KER, 1);
      @(negedge clk);
      while (sb.size() > 0) begin
         e = sb.pop_front(); n_cmp++;
         if (obs(e.sel) !== e.val) begin
            n_bad++; $display("FAIL %s: got %h want %h", e.name, obs(e.sel), e.val);
         end
      end
      @(posedge clk);
      #3 reset = 1'b0;
      #1;
      push("mid_ker", S_KER, 0);
      push("mid_epc", S_EPC, 0);
      push("mid_cause", S_CAUSE, 0);
      push("mid_mask", S_MASK, 0);
      push("mid_dbl", S_DBL, 0);
      push("mid_trap", S_TRAP, 0);
      while (sb.size() > 0) begin
         e = sb.pop_front(); n_cmp++;
         if (obs(e.sel) !== e.val) begin
            n_bad++; $display("FAIL %s: got %h want %h", e.name, obs(e.sel), e.val);
         end
      end
      next_cyc();
      reset = 1'b1;
      next_cyc();
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got still running want finished");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_irq_entry();
      test_undef_prio();
      test_return_grace();
      test_stall_defer();
      test_mask();
      test_dbl_fault();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
